// File: rtl/avalon_lsu.sv
// Load/store unit bridging the core's request/response channels to an Avalon-MM master.
// Requests are queued, issued one bus transfer at a time, and answered in order.
module avalon_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_error,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic                    write,
  input  logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   readdata
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_W);
  localparam int MAX_SIZE = OFF_W;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  req_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full, empty, push, pop;

  state_t             state_reg, state_next;
  logic               read_reg, write_reg;
  logic [ADDR_WIDTH-1:0] address_reg;
  logic [BE_W-1:0]    byteenable_reg;
  logic [DATA_WIDTH-1:0] writedata_reg;
  logic [OFF_W-1:0]   cur_offset_reg;
  logic [1:0]         cur_size_reg;
  logic               cur_signed_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic               rsp_error_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{write: req_write, size: req_size, sgn: req_signed,
                                addr: req_addr, wdata: req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Decode of the FIFO head: lane placement and legality of the access.
  req_t                  head;
  logic [OFF_W-1:0]      head_offset;
  logic [2:0]            align_mask;
  logic                  illegal;
  logic [BE_W-1:0]       lane_mask, head_be;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [ADDR_WIDTH-1:0] head_address;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_offset = head.addr[OFF_W-1:0];

  always_comb begin
    align_mask = 3'b000;
    case (head.size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign illegal      = ({1'b0, head.size} > 3'(MAX_SIZE)) || (|(head.addr[2:0] & align_mask));
  assign lane_mask    = BE_W'((16'd1 << (5'd1 << head.size)) - 16'd1);
  assign head_be      = lane_mask << head_offset;
  assign head_wdata   = head.wdata << {head_offset, 3'b000};
  assign head_address = {head.addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Load extraction: one extended candidate per access size, selected by the latched size.
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext [4];
  logic [DATA_WIDTH-1:0] load_value;

  assign shifted = readdata >> {cur_offset_reg, 3'b000};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
      localparam int B = 8 << gi;
      if (B > DATA_WIDTH) begin : g_none
        assign ext[gi] = '0;
      end else if (B == DATA_WIDTH) begin : g_full
        assign ext[gi] = shifted;
      end else begin : g_part
        assign ext[gi] = {{(DATA_WIDTH - B){cur_signed_reg & shifted[B-1]}}, shifted[B-1:0]};
      end
    end
  endgenerate

  assign load_value = ext[cur_size_reg];

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = illegal ? RESP : BUS;
        end
      end
      BUS:     if (!waitrequest) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      address_reg    <= '0;
      byteenable_reg <= '0;
      writedata_reg  <= '0;
      cur_offset_reg <= '0;
      cur_size_reg   <= '0;
      cur_signed_reg <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            cur_offset_reg <= head_offset;
            cur_size_reg   <= head.size;
            cur_signed_reg <= head.sgn;
            if (illegal) begin
              rsp_error_reg <= 1'b1;
              rsp_data_reg  <= '0;
            end else begin
              rsp_error_reg  <= 1'b0;
              read_reg       <= !head.write;
              write_reg      <= head.write;
              address_reg    <= head_address;
              byteenable_reg <= head_be;
              writedata_reg  <= head_wdata;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
            rsp_data_reg <= read_reg ? load_value : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_error  = rsp_error_reg;
  assign address    = address_reg;
  assign read       = read_reg;
  assign write      = write_reg;
  assign byteenable = byteenable_reg;
  assign writedata  = writedata_reg;

endmodule

// File: tb/tb_avalon_lsu.sv
// Directed bench for avalon_lsu: 32-bit and 64-bit instances, scoreboard of expected responses.
module tb_avalon_lsu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 0, a_req_ready, a_req_write = 0, a_req_signed = 0;
  logic [1:0]  a_req_size = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_rsp_valid, a_rsp_ready = 0, a_rsp_error;
  logic [31:0] a_rsp_data, a_address, a_writedata;
  logic        a_read, a_write, a_waitrequest = 0;
  logic [3:0]  a_byteenable;
  logic [31:0] a_readdata = 0;

  logic        b_req_valid = 0, b_req_ready, b_req_write = 0, b_req_signed = 0;
  logic [1:0]  b_req_size = 0;
  logic [31:0] b_req_addr = 0;
  logic [63:0] b_req_wdata = 0;
  logic        b_rsp_valid, b_rsp_ready = 0, b_rsp_error;
  logic [63:0] b_rsp_data, b_writedata;
  logic [31:0] b_address;
  logic        b_read, b_write, b_waitrequest = 0;
  logic [7:0]  b_byteenable;
  logic [63:0] b_readdata = 0;

  avalon_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(2)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data), .rsp_error(a_rsp_error), .address(a_address),
    .read(a_read), .write(a_write), .waitrequest(a_waitrequest),
    .writedata(a_writedata), .byteenable(a_byteenable), .readdata(a_readdata)
  );

  avalon_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .FIFO_DEPTH(2)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .rsp_error(b_rsp_error), .address(b_address),
    .read(b_read), .write(b_write), .waitrequest(b_waitrequest),
    .writedata(b_writedata), .byteenable(b_byteenable), .readdata(b_readdata)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_active(input bit w64);
    return w64 ? (b_read | b_write) : (a_read | a_write);
  endfunction

  task automatic push(input bit w64, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [31:0] addr, input logic [63:0] wd,
                      input bit track, input logic [63:0] exp_data, input bit exp_err);
    int t = 0;
    if (w64) begin
      b_req_valid = 1; b_req_write = wr; b_req_size = sz; b_req_signed = sg;
      b_req_addr = addr; b_req_wdata = wd;
    end else begin
      a_req_valid = 1; a_req_write = wr; a_req_size = sz; a_req_signed = sg;
      a_req_addr = addr; a_req_wdata = wd[31:0];
    end
    while (!(w64 ? b_req_ready : a_req_ready) && t < 20) begin
      tick();
      t++;
    end
    check("req_ready_wait", 64'(w64 ? b_req_ready : a_req_ready), 64'(1));
    tick();
    a_req_valid = 0;
    b_req_valid = 0;
    if (track) sb_q.push_back('{data: exp_data, err: exp_err});
    $display("req: w64=%0d write=%0d size=%0d signed=%0d addr=%h wdata=%h", w64, wr, sz, sg, addr, wd);
  endtask

  // Waits for the bus cycle, checks it is held stable for nwait stalled cycles plus the completing one.
  task automatic bus_phase(input bit w64, input bit wr, input logic [31:0] ea,
                           input logic [7:0] ebe, input logic [63:0] ewd, input int nwait);
    int t = 0;
    while (!bus_active(w64) && t < 20) begin
      tick();
      t++;
    end
    for (int k = 0; k <= nwait; k++) begin
      check("bus_write", 64'(w64 ? b_write : a_write), 64'(wr));
      check("bus_read",  64'(w64 ? b_read : a_read), 64'(!wr));
      check("bus_address", 64'(w64 ? b_address : a_address), 64'(ea));
      check("bus_byteenable", 64'(w64 ? b_byteenable : {4'b0, a_byteenable}), 64'(ebe));
      if (wr) check("bus_writedata", w64 ? b_writedata : {32'b0, a_writedata}, ewd);
      if (k == nwait) begin
        a_waitrequest = 0;
        b_waitrequest = 0;
      end
      tick();
    end
    check("bus_released", 64'(bus_active(w64)), 64'(0));
  endtask

  task automatic collect(input bit w64);
    int   t = 0;
    exp_t e;
    logic v;
    if (w64) b_rsp_ready = 1; else a_rsp_ready = 1;
    while (!(w64 ? b_rsp_valid : a_rsp_valid) && t < 30) begin
      tick();
      t++;
    end
    v = w64 ? b_rsp_valid : a_rsp_valid;
    check("rsp_valid", 64'(v), 64'(1));
    if (v) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL sb_underflow: observed=unexpected response expected=none");
      end else begin
        e = sb_q.pop_front();
        check("rsp_data", w64 ? b_rsp_data : {32'b0, a_rsp_data}, e.data);
        check("rsp_error", 64'(w64 ? b_rsp_error : a_rsp_error), 64'(e.err));
      end
      $display("rsp: w64=%0d data=%h error=%0d", w64, w64 ? b_rsp_data : {32'b0, a_rsp_data},
               w64 ? b_rsp_error : a_rsp_error);
      tick();
      check("rsp_drop", 64'(w64 ? b_rsp_valid : a_rsp_valid), 64'(0));
    end
    a_rsp_ready = 0;
    b_rsp_ready = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] f_addr [4];
  logic [1:0]  f_size [4];
  logic        f_sgn  [4];
  logic [63:0] f_exp  [4];

  initial begin
    int acc;

    // Reset state
    reset = 1;
    tick();
    tick();
    check("rst_req_ready", 64'(a_req_ready), 64'(1));
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(a_rsp_data), 64'(0));
    check("rst_rsp_error", 64'(a_rsp_error), 64'(0));
    check("rst_bus", 64'(bus_active(0)), 64'(0));
    check("rst_address", 64'(a_address), 64'(0));
    check("rst_byteenable", 64'(a_byteenable), 64'(0));
    check("rst_writedata", 64'(a_writedata), 64'(0));
    check("rst64_req_ready", 64'(b_req_ready), 64'(1));
    check("rst64_bus", 64'(bus_active(1)), 64'(0));
    reset = 0;
    tick();

    // Word load with zero wait: latency and single-cycle read
    a_readdata = 32'hDEADBEEF;
    push(0, 0, 2'd2, 0, 32'h1004, 64'h0, 1, 64'hDEADBEEF, 0);
    check("t1_valid_c1", 64'(a_rsp_valid), 64'(0));
    check("t1_read_c1", 64'(a_read), 64'(0));
    tick();
    check("t1_read_c2", 64'(a_read), 64'(1));
    check("t1_address", 64'(a_address), 64'(32'h1004));
    check("t1_be", 64'(a_byteenable), 64'(4'hF));
    check("t1_valid_c2", 64'(a_rsp_valid), 64'(0));
    tick();
    check("t1_read_c3", 64'(a_read), 64'(0));
    check("t1_valid_c3", 64'(a_rsp_valid), 64'(1));
    collect(0);

    // Byte loads, signed and unsigned
    a_readdata = 32'h80112233;
    push(0, 0, 2'd0, 1, 32'h2003, 64'h0, 1, 64'hFFFFFF80, 0);
    bus_phase(0, 0, 32'h2000, 8'h08, 64'h0, 0);
    collect(0);
    push(0, 0, 2'd0, 0, 32'h2003, 64'h0, 1, 64'h00000080, 0);
    bus_phase(0, 0, 32'h2000, 8'h08, 64'h0, 0);
    collect(0);

    // Halfword store under three stall cycles
    a_waitrequest = 1;
    push(0, 1, 2'd1, 0, 32'h3002, 64'h0000ABCD, 1, 64'h0, 0);
    bus_phase(0, 1, 32'h3000, 8'h0C, 64'hABCD0000, 3);
    collect(0);

    // Misaligned word and illegal dword on the 32-bit instance
    push(0, 0, 2'd2, 0, 32'h4001, 64'h0, 1, 64'h0, 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_nobus_mis", 64'(bus_active(0)), 64'(0));
      tick();
    end
    collect(0);
    push(0, 0, 2'd3, 0, 32'h4008, 64'h0, 1, 64'h0, 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_nobus_dw", 64'(bus_active(0)), 64'(0));
      tick();
    end
    collect(0);

    // FIFO fill with the response channel stalled, then in-order drain
    a_readdata = 32'h80112233;
    f_addr = '{32'h5000, 32'h5001, 32'h5002, 32'h5004};
    f_size = '{2'd2, 2'd0, 2'd1, 2'd2};
    f_sgn  = '{1'b0, 1'b0, 1'b1, 1'b0};
    f_exp  = '{64'h80112233, 64'h22, 64'hFFFF8011, 64'h80112233};
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      a_req_valid = 1; a_req_write = 0;
      a_req_addr = f_addr[acc]; a_req_size = f_size[acc]; a_req_signed = f_sgn[acc];
      if (a_req_ready) begin
        sb_q.push_back('{data: f_exp[acc], err: 1'b0});
        $display("req: fifo idx=%0d addr=%h", acc, f_addr[acc]);
        acc++;
      end
      tick();
    end
    check("t5_ready_full", 64'(a_req_ready), 64'(0));
    check("t5_accepted", 64'(acc), 64'(3));
    a_req_valid = 0;
    for (int i = 0; i < acc; i++) collect(0);
    check("t5_ready_after", 64'(a_req_ready), 64'(1));

    // Reset in the middle of a stalled read
    a_waitrequest = 1;
    push(0, 0, 2'd2, 0, 32'h6000, 64'h0, 0, 64'h0, 0);
    push(0, 0, 2'd2, 0, 32'h6004, 64'h0, 0, 64'h0, 0);
    acc = 0;
    while (!a_read && acc < 20) begin
      tick();
      acc++;
    end
    check("t6_read_before", 64'(a_read), 64'(1));
    reset = 1;
    tick();
    check("t6_read_after", 64'(a_read), 64'(0));
    check("t6_req_ready", 64'(a_req_ready), 64'(1));
    check("t6_rsp_valid", 64'(a_rsp_valid), 64'(0));
    reset = 0;
    a_waitrequest = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_idle_valid", 64'(a_rsp_valid), 64'(0));
      check("t6_idle_bus", 64'(bus_active(0)), 64'(0));
    end

    // 64-bit instance: full dword and signed byte in an upper lane
    b_readdata = 64'h0123456789ABCDEF;
    push(1, 0, 2'd3, 0, 32'h10, 64'h0, 1, 64'h0123456789ABCDEF, 0);
    bus_phase(1, 0, 32'h10, 8'hFF, 64'h0, 0);
    collect(1);
    push(1, 0, 2'd0, 1, 32'h13, 64'h0, 1, 64'hFFFFFFFFFFFFFF89, 0);
    bus_phase(1, 0, 32'h10, 8'h08, 64'h0, 0);
    collect(1);

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
